// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_port_arbiter : two-requester single-port memory arbiter, port 0 priority
//                    with port-1 starvation guard and read-data return routing
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int               CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  typedef enum logic [0:0] {
    ST_PRIO0  = 1'b0,
    ST_FORCE1 = 1'b1
  } arb_state_e;

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              en_q, en_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [RD_LAT-1:0] pv_q;
  logic [RD_LAT-1:0] pp_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              elig0, elig1;

  // A port whose grant is on the bus this cycle must not be issued again.
  assign elig0 = req0 & ~gnt0_q;
  assign elig1 = req1 & ~gnt1_q;

  always_comb begin
    gnt0_d = 1'b0;
    gnt1_d = 1'b0;
    cnt_d  = '0;
    unique case (state_q)
      ST_FORCE1: begin
        if (elig1) begin
          gnt1_d = 1'b1;
        end else if (elig0) begin
          gnt0_d = 1'b1;
        end
      end
      default: begin
        if (elig0) begin
          gnt0_d = 1'b1;
          cnt_d  = elig1 ? cnt_q + CNT_W'(1) : '0;
        end else if (elig1) begin
          gnt1_d = 1'b1;
        end
      end
    endcase
    state_d = (cnt_d == CNT_MAX) ? ST_FORCE1 : ST_PRIO0;

    en_d    = gnt0_d | gnt1_d;
    we_d    = gnt1_d ? we1 : (gnt0_d & we0);
    addr_d  = gnt1_d ? addr1  : (gnt0_d ? addr0  : addr_q);
    wdata_d = gnt1_d ? wdata1 : (gnt0_d ? wdata0 : wdata_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_PRIO0;
      cnt_q   <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      en_q    <= en_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Read-return pipe: stage 0 is loaded the cycle after issue, so the tail
  // lines up with mem_rdata RD_LAT cycles after the grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      pv_q     <= '0;
      pp_q     <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      pv_q[0] <= en_q & ~we_q;
      pp_q[0] <= gnt1_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pp_q[i] <= pp_q[i-1];
      end
      if (rvalid0) rdata0_q <= mem_rdata;
      if (rvalid1) rdata1_q <= mem_rdata;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign mem_en    = en_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rvalid0   = pv_q[RD_LAT-1] & ~pp_q[RD_LAT-1];
  assign rvalid1   = pv_q[RD_LAT-1] &  pp_q[RD_LAT-1];
  assign rdata0    = rvalid0 ? mem_rdata : rdata0_q;
  assign rdata1    = rvalid1 ? mem_rdata : rdata1_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter : directed + random stimulus against a behavioural model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;
  localparam int RD_LAT    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1, mem_rdata;
  logic              gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we;
  logic [DATA_W-1:0] rdata0, rdata1, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int n_total, n_pass, n_fail, cyc;

  // Memory attached to the DUT's memory port, and the model's own view of it.
  logic [7:0] tb_mem  [256];
  logic [7:0] ref_mem [256];
  logic [7:0] rd_line [RD_LAT];

  // Reference model state: expected outputs visible in the current cycle.
  logic       m_g0, m_g1, m_en, m_we, m_rst;
  logic [7:0] m_addr, m_wdata, e_rd0, e_rd1;
  int         wait_n;
  logic       pend_v [8];
  logic       pend_p [8];
  logic [7:0] pend_d [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    logic       e0, e1, en_s, we_s, xv0, xv1;
    logic [7:0] a_s, d_s;
    int         win, slot;
    en_s = mem_en; we_s = mem_we; a_s = mem_addr; d_s = mem_wdata;
    m_rst = reset;
    if (reset) begin
      m_g0 = 1'b0; m_g1 = 1'b0; m_en = 1'b0; m_we = 1'b0;
      m_addr = 8'h00; m_wdata = 8'h00; e_rd0 = 8'h00; e_rd1 = 8'h00;
      wait_n = 0;
      for (int i = 0; i < 8; i++) pend_v[i] = 1'b0;
    end else begin
      e0 = req0 && !m_g0;
      e1 = req1 && !m_g1;
      if (e1 && (!e0 || wait_n >= MAX_BURST)) win = 1;
      else if (e0)                            win = 0;
      else                                    win = -1;
      wait_n = (win == 0 && e1) ? wait_n + 1 : 0;
      m_g0 = (win == 0);
      m_g1 = (win == 1);
      m_en = (win >= 0);
      m_we = 1'b0;
      if (win >= 0) begin
        m_we    = (win == 1) ? we1 : we0;
        m_addr  = (win == 1) ? addr1 : addr0;
        m_wdata = (win == 1) ? wdata1 : wdata0;
        if (m_we) ref_mem[m_addr] = m_wdata;
        else begin
          slot = (cyc + 1 + RD_LAT) % 8;
          pend_v[slot] = 1'b1;
          pend_p[slot] = (win == 1);
          pend_d[slot] = ref_mem[m_addr];
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    for (int i = RD_LAT - 1; i > 0; i--) rd_line[i] = rd_line[i-1];
    rd_line[0] = 8'($urandom);
    if (en_s === 1'b1) begin
      if (we_s) tb_mem[a_s] = d_s;
      else      rd_line[0] = tb_mem[a_s];
    end
    mem_rdata = rd_line[RD_LAT-1];
    #1;
    slot = cyc % 8;
    xv0 = pend_v[slot] && !pend_p[slot];
    xv1 = pend_v[slot] &&  pend_p[slot];
    if (xv0) e_rd0 = pend_d[slot];
    if (xv1) e_rd1 = pend_d[slot];
    pend_v[slot] = 1'b0;
    chk("gnt0",    32'(gnt0),    32'(m_g0));
    chk("gnt1",    32'(gnt1),    32'(m_g1));
    chk("mem_en",  32'(mem_en),  32'(m_en));
    chk("mem_we",  32'(mem_we),  32'(m_we));
    chk("rvalid0", 32'(rvalid0), 32'(xv0));
    chk("rvalid1", 32'(rvalid1), 32'(xv1));
    chk("rdata0",  32'(rdata0),  32'(e_rd0));
    chk("rdata1",  32'(rdata1),  32'(e_rd1));
    if (m_en || m_rst) begin
      chk("mem_addr",  32'(mem_addr),  32'(m_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    end
  endtask

  task automatic acc0(input logic w, input logic [7:0] a, input logic [7:0] d);
    req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
    step();
    for (int k = 0; k < 8 && !m_g0; k++) step();
    req0 = 1'b0;
  endtask

  task automatic acc1(input logic w, input logic [7:0] a, input logic [7:0] d);
    req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
    step();
    for (int k = 0; k < 8 && !m_g1; k++) step();
    req1 = 1'b0;
  endtask

  initial begin
    n_total = 0; n_pass = 0; n_fail = 0; cyc = 0;
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00; mem_rdata = 8'h00;
    m_g0 = 1'b0; m_g1 = 1'b0; m_en = 1'b0; m_we = 1'b0; m_rst = 1'b1;
    m_addr = 8'h00; m_wdata = 8'h00; e_rd0 = 8'h00; e_rd1 = 8'h00; wait_n = 0;
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    for (int i = 0; i < RD_LAT; i++) rd_line[i] = 8'h00;
    for (int i = 0; i < 8; i++) begin
      pend_v[i] = 1'b0; pend_p[i] = 1'b0; pend_d[i] = 8'h00;
    end

    // Reset held with both requests active, then released.
    repeat (3) step();
    reset = 1'b0;
    repeat (3) step();
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) step();

    // Port 0 write then read-back.
    acc0(1'b1, 8'h12, 8'hA5);
    acc0(1'b0, 8'h12, 8'h00);
    repeat (RD_LAT + 1) step();
    chk("wr_rd_port0", 32'(rdata0), 32'h0000_00A5);

    // Both ports requesting continuously.
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 24; k++) begin
      we0 = 1'($urandom); we1 = 1'($urandom);
      addr0 = 8'($urandom_range(0, 15)); addr1 = 8'($urandom_range(16, 31));
      wdata0 = 8'($urandom); wdata1 = 8'($urandom);
      step();
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (RD_LAT + 1) step();

    // Port 1 alone, then port 0 interleaved.
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h40;
    repeat (10) step();
    for (int k = 0; k < 12; k++) begin
      req0 = (k % 3 == 0); we0 = 1'b0; addr0 = 8'(8'h50 + k);
      step();
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (RD_LAT + 1) step();

    // Read routing with distinct data per port.
    acc0(1'b1, 8'h01, 8'h11);
    acc1(1'b1, 8'h02, 8'h22);
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h02;
    repeat (8) step();
    req0 = 1'b0; req1 = 1'b0;
    repeat (RD_LAT + 1) step();
    chk("route_rdata0", 32'(rdata0), 32'h0000_0011);
    chk("route_rdata1", 32'(rdata1), 32'h0000_0022);

    // Reset right after a read grant: that read must never return.
    acc0(1'b0, 8'h30, 8'h00);
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    repeat (RD_LAT + 3) step();

    // Randomised traffic with occasional resets.
    for (int k = 0; k < 600; k++) begin
      reset  = ($urandom_range(0, 99) == 0);
      req0   = ($urandom_range(0, 2) != 0);
      req1   = ($urandom_range(0, 2) != 0);
      we0    = 1'($urandom); we1 = 1'($urandom);
      addr0  = 8'($urandom_range(0, 15)); addr1 = 8'($urandom_range(0, 15));
      wdata0 = 8'($urandom); wdata1 = 8'($urandom);
      step();
    end
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (RD_LAT + 2) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
